// File: rtl/shower_win.sv
// Anode shower detector: windowed hit/layer counts classified against three hit thresholds, 2 clocks latency.
// No backpressure; one classification per clock. Optional dead time after a shower under SHOWER_HOLDOFF_EN.
module shower_win #(
   parameter int NLY = 6,
   parameter int NW  = 32,
   parameter int CW  = 10,
   parameter int WIN = 1,
   localparam int LYW = $clog2(NLY + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NLY*NW-1:0] ly,
   input  logic [CW-1:0]     th_loose,
   input  logic [CW-1:0]     th_nominal,
   input  logic [CW-1:0]     th_tight,
   input  logic [LYW-1:0]    ly_th,
   input  logic [7:0]        holdoff,
   output logic [1:0]        shower_int,
   output logic [CW-1:0]     shower_cnt,
   output logic [LYW-1:0]    shower_lyc
);

   localparam int PW = $clog2(NLY * NW + 1);
   localparam logic [CW+2:0] SMAX = {3'b000, {CW{1'b1}}};

   logic [PW-1:0]  pc;
   logic [CW-1:0]  h_in;
   logic [NLY-1:0] m_in;
   logic [CW-1:0]  h [WIN];
   logic [NLY-1:0] m [WIN];

   logic [CW+2:0]  sum;
   logic [NLY-1:0] mor;
   logic [LYW-1:0] lyc_d;
   logic [CW-1:0]  win_cnt;
   logic [LYW-1:0] win_lyc;
   logic [1:0]     code;

   always_comb begin
      pc = '0;
      for (int i = 0; i < NLY * NW; i++) pc = pc + PW'(ly[i]);
      if (int'(pc) > (2 ** CW) - 1) h_in = '1;
      else                          h_in = CW'(pc);
      for (int i = 0; i < NLY; i++) m_in[i] = |ly[i*NW +: NW];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int j = 0; j < WIN; j++) begin
            h[j] <= '0;
            m[j] <= '0;
         end
      end else begin
         h[0] <= h_in;
         m[0] <= m_in;
         for (int j = 1; j < WIN; j++) begin
            h[j] <= h[j-1];
            m[j] <= m[j-1];
         end
      end
   end

   // A layer seen in any crossing of the window counts once.
   always_comb begin
      sum = '0;
      mor = '0;
      for (int j = 0; j < WIN; j++) begin
         sum = sum + {3'b000, h[j]};
         mor = mor | m[j];
      end
      lyc_d = '0;
      for (int i = 0; i < NLY; i++) lyc_d = lyc_d + LYW'(mor[i]);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         win_cnt <= '0;
         win_lyc <= '0;
      end else begin
         win_cnt <= (sum > SMAX) ? '1 : sum[CW-1:0];
         win_lyc <= lyc_d;
      end
   end

   always_comb begin
      code = 2'd0;
      if (win_lyc >= ly_th) begin
         if (win_cnt >= th_tight)        code = 2'd3;
         else if (win_cnt >= th_nominal) code = 2'd2;
         else if (win_cnt >= th_loose)   code = 2'd1;
      end
   end

`ifdef SHOWER_HOLDOFF_EN
   logic [7:0] hold_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shower_int <= 2'd0;
         shower_cnt <= '0;
         shower_lyc <= '0;
         hold_cnt   <= 8'd0;
      end else begin
         shower_cnt <= win_cnt;
         shower_lyc <= win_lyc;
         if (hold_cnt != 8'd0) begin
            shower_int <= 2'd0;
            hold_cnt   <= hold_cnt - 8'd1;
         end else begin
            shower_int <= code;
            if (code != 2'd0) hold_cnt <= holdoff;
         end
      end
   end
`else
   logic unused_holdoff;
   assign unused_holdoff = ^holdoff;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shower_int <= 2'd0;
         shower_cnt <= '0;
         shower_lyc <= '0;
      end else begin
         shower_int <= code;
         shower_cnt <= win_cnt;
         shower_lyc <= win_lyc;
      end
   end
`endif

endmodule

// File: tb/tb_shower_win.sv
// Bench for shower_win: three instances (WIN 1/4/8) against a window model built from raw hit history.
`timescale 1ns/1ps
module tb_shower_win;

   localparam int NLY  = 6;
   localparam int NW   = 32;
   localparam int CW   = 10;
   localparam int LYW  = $clog2(NLY + 1);
   localparam int NB   = NLY * NW;
   localparam int ND   = 3;
   localparam int HD   = 10;
   localparam int CMAX = (1 << CW) - 1;

   logic           clk = 1'b0;
   logic           rst;
   logic [NB-1:0]  ly;
   logic [CW-1:0]  th_loose, th_nominal, th_tight;
   logic [LYW-1:0] ly_th;
   logic [7:0]     holdoff;

   logic [1:0]     s_int [ND];
   logic [CW-1:0]  s_cnt [ND];
   logic [LYW-1:0] s_lyc [ND];

   int checks = 0;
   int errors = 0;

   logic [NB-1:0] hist [HD];
   int m_int [ND];
   int m_cnt [ND];
   int m_lyc [ND];
   int m_hc  [ND];

   for (genvar g = 0; g < ND; g++) begin : g_dut
      shower_win #(.NLY(NLY), .NW(NW), .CW(CW), .WIN(g == 0 ? 1 : (g == 1 ? 4 : 8))) u_dut (
         .clk(clk), .rst(rst), .ly(ly),
         .th_loose(th_loose), .th_nominal(th_nominal), .th_tight(th_tight),
         .ly_th(ly_th), .holdoff(holdoff),
         .shower_int(s_int[g]), .shower_cnt(s_cnt[g]), .shower_lyc(s_lyc[g])
      );
   end

   always #5 clk = ~clk;

   task automatic model_clear();
      for (int i = 0; i < HD; i++) hist[i] = '0;
      for (int g = 0; g < ND; g++) begin
         m_int[g] = 0; m_cnt[g] = 0; m_lyc[g] = 0; m_hc[g] = 0;
      end
   endtask

   // Output after edge n reflects crossings n-2 .. n-WIN-1 and thresholds present at edge n.
   task automatic model_edge();
      for (int i = HD - 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = ly;
      for (int g = 0; g < ND; g++) begin
         int w, cnt, pc, lmask, lyc, code;
         w = (g == 0) ? 1 : ((g == 1) ? 4 : 8);
         cnt = 0; lmask = 0;
         for (int j = 2; j < w + 2; j++) begin
            pc = $countones(hist[j]);
            if (pc > CMAX) pc = CMAX;
            cnt += pc;
            for (int l = 0; l < NLY; l++)
               if (hist[j][l*NW +: NW] != '0) lmask |= (1 << l);
         end
         if (cnt > CMAX) cnt = CMAX;
         lyc = $countones(lmask);
         code = 0;
         if (lyc >= int'(ly_th)) begin
            if (cnt >= int'(th_tight))        code = 3;
            else if (cnt >= int'(th_nominal)) code = 2;
            else if (cnt >= int'(th_loose))   code = 1;
         end
`ifdef SHOWER_HOLDOFF_EN
         if (m_hc[g] != 0) begin
            code = 0;
            m_hc[g]--;
         end else if (code != 0) begin
            m_hc[g] = int'(holdoff);
         end
`endif
         m_int[g] = code; m_cnt[g] = cnt; m_lyc[g] = lyc;
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      if (rst) model_clear();
      else     model_edge();
      @(negedge clk);
   endtask

   task automatic set_thr(input int lo, input int no, input int ti, input int lt);
      th_loose = CW'(lo); th_nominal = CW'(no); th_tight = CW'(ti); ly_th = LYW'(lt);
   endtask

   task automatic idle(input int n);
      ly = '0;
      repeat (n) cycle();
   endtask

   function automatic logic [NB-1:0] layer_pat(input int nly, input logic [NW-1:0] word);
      logic [NB-1:0] v;
      v = '0;
      for (int l = 0; l < nly; l++) v[l*NW +: NW] = word;
      return v;
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      ly = '0;
      set_thr(20, 40, 60, 5);
      #1;
      for (int g = 0; g < ND; g++) begin
         checks++;
         if (s_int[g] !== 2'd0 || s_cnt[g] !== '0 || s_lyc[g] !== '0) begin
            errors++;
            $display("FAIL reset g%0d: int/cnt/lyc got %0d/%0d/%0d want 0/0/0", g, s_int[g], s_cnt[g], s_lyc[g]);
         end
      end
      @(negedge clk);
      rst = 1'b0;
      model_clear();
      for (int c = 0; c < 10; c++) begin
         cycle();
         for (int g = 0; g < ND; g++) begin
            checks++;
            if (s_int[g] !== 2'd0 || s_cnt[g] !== '0) begin
               errors++;
               $display("FAIL idle g%0d c%0d: int/cnt got %0d/%0d want 0/0", g, c, s_int[g], s_cnt[g]);
            end
         end
      end
   endtask

   task automatic test_burst(input int nly, input logic [NW-1:0] word, input int want_int, input int want_lyc);
      set_thr(20, 40, 60, 5);
      idle(10);
      ly = layer_pat(nly, word);
      for (int c = 0; c < 7; c++) begin
         cycle();
         if (c == 0) ly = '0;
         checks++;
         if (c == 2) begin
            if (int'(s_int[0]) !== want_int || int'(s_cnt[0]) !== 60 || int'(s_lyc[0]) !== want_lyc) begin
               errors++;
               $display("FAIL burst%0d c%0d: int/cnt/lyc got %0d/%0d/%0d want %0d/60/%0d",
                        nly, c, s_int[0], s_cnt[0], s_lyc[0], want_int, want_lyc);
            end
         end else if (s_int[0] !== 2'd0) begin
            errors++;
            $display("FAIL burst%0d c%0d: int got %0d want 0", nly, c, s_int[0]);
         end
         for (int g = 0; g < ND; g++) begin
            checks++;
            if (s_int[g] !== 2'(m_int[g]) || s_cnt[g] !== CW'(m_cnt[g]) || s_lyc[g] !== LYW'(m_lyc[g])) begin
               errors++;
               $display("FAIL burst model g%0d c%0d: got %0d/%0d/%0d want %0d/%0d/%0d",
                        g, c, s_int[g], s_cnt[g], s_lyc[g], m_int[g], m_cnt[g], m_lyc[g]);
            end
         end
      end
   endtask

   task automatic test_window();
      int exp_w [9];
      exp_w = '{0, 0, 10, 20, 30, 30, 20, 10, 0};
      set_thr(30, 100, 200, 1);
      idle(10);
      ly = '0;
      ly[9:0] = '1;
      for (int c = 0; c < 9; c++) begin
         cycle();
         if (c == 2) ly = '0;
         checks++;
         if (int'(s_cnt[1]) !== exp_w[c] || int'(s_int[1]) !== ((exp_w[c] == 30) ? 1 : 0)) begin
            errors++;
            $display("FAIL window c%0d: cnt/int got %0d/%0d want %0d/%0d",
                     c, s_cnt[1], s_int[1], exp_w[c], (exp_w[c] == 30) ? 1 : 0);
         end
      end
   endtask

   task automatic test_saturate();
      set_thr(20, 40, 60, 5);
      idle(10);
      ly = '1;
      for (int c = 0; c < 12; c++) begin
         cycle();
         if (c == 7) ly = '0;
         if (c >= 2 && c <= 9) begin
            int want;
            want = 192 * (c - 1);
            if (want > CMAX) want = CMAX;
            checks++;
            if (int'(s_cnt[2]) !== want || int'(s_lyc[2]) !== 6) begin
               errors++;
               $display("FAIL saturate c%0d: cnt/lyc got %0d/%0d want %0d/6", c, s_cnt[2], s_lyc[2], want);
            end
         end
         for (int g = 0; g < ND; g++) begin
            checks++;
            if (s_int[g] !== 2'(m_int[g]) || s_cnt[g] !== CW'(m_cnt[g]) || s_lyc[g] !== LYW'(m_lyc[g])) begin
               errors++;
               $display("FAIL saturate model g%0d c%0d: got %0d/%0d/%0d want %0d/%0d/%0d",
                        g, c, s_int[g], s_cnt[g], s_lyc[g], m_int[g], m_cnt[g], m_lyc[g]);
            end
         end
      end
   endtask

   task automatic rand_ly();
      for (int l = 0; l < NLY; l++) begin
         logic [31:0] r;
         r = $urandom;
         repeat ($urandom_range(0, 4)) r &= $urandom;
         if ($urandom_range(0, 15) == 0) r = '1;
         if ($urandom_range(0, 3) == 0) r = '0;
         ly[l*NW +: NW] = r;
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         if (c % 8 == 0)
            set_thr($urandom_range(0, 300), $urandom_range(0, 500), $urandom_range(0, 800), $urandom_range(0, 6));
         rand_ly();
         cycle();
         for (int g = 0; g < ND; g++) begin
            checks++;
            if (s_int[g] !== 2'(m_int[g]) || s_cnt[g] !== CW'(m_cnt[g]) || s_lyc[g] !== LYW'(m_lyc[g])) begin
               errors++;
               $display("FAIL random g%0d c%0d: got %0d/%0d/%0d want %0d/%0d/%0d",
                        g, c, s_int[g], s_cnt[g], s_lyc[g], m_int[g], m_cnt[g], m_lyc[g]);
            end
         end
      end
   endtask

   task automatic test_zero_thresholds();
      set_thr(0, 300, 600, 0);
      for (int c = 0; c < 20; c++) begin
         if (c < 10) rand_ly();
         else        ly = '0;
         cycle();
         for (int g = 0; g < ND; g++) begin
            checks++;
            if (s_int[g] === 2'd0 || s_int[g] !== 2'(m_int[g])) begin
               errors++;
               $display("FAIL zero_thr g%0d c%0d: int got %0d want %0d (nonzero)", g, c, s_int[g], m_int[g]);
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      set_thr(1, 40, 60, 1);
      idle(10);
      ly = layer_pat(5, 32'h0000_0FFF);
      cycle();
      cycle();
      cycle();
      #2 rst = 1'b1;
      #1;
      for (int g = 0; g < ND; g++) begin
         checks++;
         if (s_int[g] !== 2'd0 || s_cnt[g] !== '0 || s_lyc[g] !== '0) begin
            errors++;
            $display("FAIL mid_reset g%0d: int/cnt/lyc got %0d/%0d/%0d want 0/0/0", g, s_int[g], s_cnt[g], s_lyc[g]);
         end
      end
      model_clear();
      cycle();
      rst = 1'b0;
      ly = '0;
      for (int c = 0; c < 10; c++) begin
         cycle();
         for (int g = 0; g < ND; g++) begin
            checks++;
            if (s_int[g] !== 2'd0 || s_int[g] !== 2'(m_int[g])) begin
               errors++;
               $display("FAIL post_reset g%0d c%0d: int got %0d want 0", g, c, s_int[g]);
            end
         end
      end
      ly = layer_pat(1, 32'h0000_0001);
      for (int c = 0; c < 4; c++) begin
         cycle();
         if (c == 0) ly = '0;
         checks++;
         if (int'(s_int[0]) !== ((c == 2) ? 1 : 0) || s_int[0] !== 2'(m_int[0])) begin
            errors++;
            $display("FAIL fresh_hit c%0d: int got %0d want %0d", c, s_int[0], (c == 2) ? 1 : 0);
         end
      end
   endtask

`ifdef SHOWER_HOLDOFF_EN
   task automatic test_holdoff();
      set_thr(20, 40, 60, 5);
      idle(12);
      holdoff = 8'd3;
      ly = layer_pat(5, 32'h0000_0FFF);
      for (int c = 0; c < 14; c++) begin
         int want;
         cycle();
         want = (c >= 2 && (c - 2) % 4 == 0) ? 3 : 0;
         checks++;
         if (int'(s_int[0]) !== want || int'(s_cnt[0]) !== ((c >= 2) ? 60 : 0)) begin
            errors++;
            $display("FAIL holdoff c%0d: int/cnt got %0d/%0d want %0d/%0d", c, s_int[0], s_cnt[0], want, (c >= 2) ? 60 : 0);
         end
         for (int g = 0; g < ND; g++) begin
            checks++;
            if (s_int[g] !== 2'(m_int[g]) || s_cnt[g] !== CW'(m_cnt[g])) begin
               errors++;
               $display("FAIL holdoff model g%0d c%0d: int/cnt got %0d/%0d want %0d/%0d",
                        g, c, s_int[g], s_cnt[g], m_int[g], m_cnt[g]);
            end
         end
      end
      ly = '0;
      holdoff = 8'd0;
      idle(12);
   endtask
`endif

   initial begin
      holdoff = 8'd0;
      model_clear();
      test_reset();
      test_burst(5, 32'h0000_0FFF, 3, 5);
      test_burst(4, 32'h0000_7FFF, 0, 4);
      test_window();
      test_saturate();
      test_random();
      test_zero_thresholds();
`ifdef SHOWER_HOLDOFF_EN
      test_holdoff();
`endif
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
